decimate32: RTL and testbench

DECIMATE32 -- requirements
Module: decimate32

---
 rtl/decimate32.sv | 145 ++++++++++++++
 tb/tb_decimate32.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decimate32.sv
// decimate32: 3rd-order CIC decimator (R=32, M=1), 16-bit signed in and out, unity DC gain.
// Optional macro DECIMATE32_ROUND_EN selects round-half-up with saturation; the default build truncates.
module decimate32 (
    input  logic               ACLK,
    input  logic               ARSTN,
    input  logic signed [15:0] din,
    input  logic               din_valid,
    input  logic               phase_clr,
    output logic signed [15:0] dout,
    output logic               dout_valid
);

    localparam int ACC_W = 31;

    typedef logic signed [ACC_W-1:0] acc_t;

    acc_t integ1_q, integ1_d;
    acc_t integ2_q, integ2_d;
    acc_t integ3_q, integ3_d;
    acc_t integ3Dly_q, integ3Dly_d;
    acc_t comb1_q, comb1_d;
    acc_t comb1Dly_q, comb1Dly_d;
    acc_t comb2_q, comb2_d;
    acc_t comb2Dly_q, comb2Dly_d;
    acc_t comb3_q, comb3_d;

    logic [4:0]         phaseCnt_q, phaseCnt_d;
    logic [3:0]         stbPipe_q, stbPipe_d;
    logic signed [15:0] dout_q, dout_d;
    logic               doutValid_q, doutValid_d;
    logic               decimStrobe;
    logic signed [15:0] scaled;

    // A sample arriving with phase_clr counts as phase 0, which also cancels a would-be phase-31 strobe.
    always_comb begin
        integ1_d    = integ1_q;
        integ2_d    = integ2_q;
        integ3_d    = integ3_q;
        phaseCnt_d  = phaseCnt_q;
        decimStrobe = 1'b0;

        if (din_valid) begin
            integ1_d = integ1_q + {{(ACC_W-16){din[15]}}, din};
            integ2_d = integ2_q + integ1_q;
            integ3_d = integ3_q + integ2_q;
        end

        if (phase_clr) begin
            phaseCnt_d = din_valid ? 5'd1 : 5'd0;
        end else if (din_valid) begin
            phaseCnt_d  = phaseCnt_q + 5'd1;
            decimStrobe = (phaseCnt_q == 5'd31);
        end

        stbPipe_d = {stbPipe_q[2:0], decimStrobe};
    end

    always_comb begin
        integ3Dly_d = integ3Dly_q;
        comb1_d     = comb1_q;
        comb1Dly_d  = comb1Dly_q;
        comb2_d     = comb2_q;
        comb2Dly_d  = comb2Dly_q;
        comb3_d     = comb3_q;
        dout_d      = dout_q;
        doutValid_d = stbPipe_q[3];

        if (stbPipe_q[0]) begin
            comb1_d     = integ3_q - integ3Dly_q;
            integ3Dly_d = integ3_q;
        end
        if (stbPipe_q[1]) begin
            comb2_d    = comb1_q - comb1Dly_q;
            comb1Dly_d = comb1_q;
        end
        if (stbPipe_q[2]) begin
            comb3_d    = comb2_q - comb2Dly_q;
            comb2Dly_d = comb2_q;
        end
        if (stbPipe_q[3]) begin
            dout_d = scaled;
        end
    end

`ifdef DECIMATE32_ROUND_EN
    logic [ACC_W:0] roundSum;
    logic           unusedRoundBits;

    // Only the positive extreme can overflow after adding the half-LSB.
    always_comb begin
        roundSum = {comb3_q[ACC_W-1], comb3_q} + 32'd16384;
        if (roundSum[ACC_W] != roundSum[ACC_W-1]) begin
            scaled = roundSum[ACC_W] ? 16'sh8000 : 16'sh7FFF;
        end else begin
            scaled = roundSum[ACC_W-1:15];
        end
    end

    assign unusedRoundBits = ^roundSum[14:0];
`else
    logic unusedTruncBits;

    always_comb begin
        scaled = comb3_q[ACC_W-1:15];
    end

    assign unusedTruncBits = ^comb3_q[14:0];
`endif

    always_ff @(posedge ACLK or negedge ARSTN) begin
        if (!ARSTN) begin
            integ1_q    <= '0;
            integ2_q    <= '0;
            integ3_q    <= '0;
            integ3Dly_q <= '0;
            comb1_q     <= '0;
            comb1Dly_q  <= '0;
            comb2_q     <= '0;
            comb2Dly_q  <= '0;
            comb3_q     <= '0;
            phaseCnt_q  <= '0;
            stbPipe_q   <= '0;
            dout_q      <= '0;
            doutValid_q <= 1'b0;
        end else begin
            integ1_q    <= integ1_d;
            integ2_q    <= integ2_d;
            integ3_q    <= integ3_d;
            integ3Dly_q <= integ3Dly_d;
            comb1_q     <= comb1_d;
            comb1Dly_q  <= comb1Dly_d;
            comb2_q     <= comb2_d;
            comb2Dly_q  <= comb2Dly_d;
            comb3_q     <= comb3_d;
            phaseCnt_q  <= phaseCnt_d;
            stbPipe_q   <= stbPipe_d;
            dout_q      <= dout_d;
            doutValid_q <= doutValid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = doutValid_q;

endmodule

// File: tb/tb_decimate32.sv
// tb_decimate32: directed self-checking bench for the decimate32 CIC decimator.
// Expected output values come from hand-derived constants or an exact-integer CIC model.
module tb_decimate32;

    logic               ACLK = 1'b0;
    logic               ARSTN;
    logic signed [15:0] din;
    logic               din_valid;
    logic               phase_clr;
    logic signed [15:0] dout;
    logic               dout_valid;

    int testsRun    = 0;
    int testsFailed = 0;
    int cyc         = 0;
    int tbPhase     = 0;

    int pulseCyc[$];
    int pulseVal[$];
    int capEdges[$];

    decimate32 dut (
        .ACLK       (ACLK),
        .ARSTN      (ARSTN),
        .din        (din),
        .din_valid  (din_valid),
        .phase_clr  (phase_clr),
        .dout       (dout),
        .dout_valid (dout_valid)
    );

    always #5 ACLK = ~ACLK;

    always @(posedge ACLK) cyc <= cyc + 1;

    // Record every output pulse with the edge number that produced it.
    always @(negedge ACLK) begin
        if (dout_valid === 1'b1) begin
            pulseCyc.push_back(cyc);
            pulseVal.push_back(int'(dout));
        end
    end

    task automatic applyStimulus(input logic v, input int x, input logic c);
        din_valid = v;
        din       = 16'(x);
        phase_clr = c;
        @(posedge ACLK);
        #1;
        din_valid = 1'b0;
        phase_clr = 1'b0;
    endtask

    task automatic clearLogs();
        pulseCyc.delete();
        pulseVal.delete();
        capEdges.delete();
    endtask

    // Sends n accepted samples, noting the capture edge of every phase-31 sample.
    task automatic sendSamples(input int n, input int x, input bit gap);
        for (int i = 0; i < n; i++) begin
            applyStimulus(1'b1, x, 1'b0);
            if (tbPhase == 31) capEdges.push_back(cyc);
            tbPhase = (tbPhase + 1) % 32;
            if (gap) applyStimulus(1'b0, 0, 1'b0);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(1'b0, 0, 1'b0);
    endtask

    task automatic doReset();
        ARSTN = 1'b0;
        #1;
        repeat (2) @(posedge ACLK);
        #1;
        ARSTN   = 1'b1;
        tbPhase = 0;
        clearLogs();
    endtask

    // Checks pulse count, timing against capture edges, and settled value from output 3 on.
    task automatic checkFrames(input string name, input int expCount, input int expVal);
        testsRun++;
        if (pulseCyc.size() !== expCount) begin
            testsFailed++;
            $display("[TB] FAIL %s_count: got %0d pulses, expected %0d", name, pulseCyc.size(), expCount);
        end
        for (int j = 0; j < pulseCyc.size() && j < capEdges.size(); j++) begin
            testsRun++;
            if (pulseCyc[j] !== capEdges[j] + 4) begin
                testsFailed++;
                $display("[TB] FAIL %s_latency[%0d]: pulse at edge %0d, expected %0d", name, j, pulseCyc[j], capEdges[j] + 4);
            end
            if (j >= 2) begin
                testsRun++;
                if (pulseVal[j] !== expVal) begin
                    testsFailed++;
                    $display("[TB] FAIL %s_value[%0d]: got %0d, expected %0d", name, j, pulseVal[j], expVal);
                end
            end
        end
    endtask

    task automatic test_reset();
        ARSTN     = 1'b0;
        din_valid = 1'b1;
        din       = 16'sd1234;
        phase_clr = 1'b0;
        repeat (3) @(posedge ACLK);
        #1;
        testsRun++;
        if (dout !== 16'sd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_dout: got %0d, expected 0", dout);
        end
        testsRun++;
        if (dout_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_valid: got %b, expected 0", dout_valid);
        end
        din_valid = 1'b0;
        ARSTN     = 1'b1;
    endtask

    task automatic test_dc();
        doReset();
        sendSamples(320, 1000, 1'b0);
        idle(6);
        checkFrames("dc1000", 10, 1000);
        testsRun++;
        if (dout !== 16'sd1000 || dout_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL dc1000_hold: got dout=%0d valid=%b, expected 1000 and 0", dout, dout_valid);
        end
    endtask

    task automatic test_full_scale();
        int vals[2];
        vals[0] = 32767;
        vals[1] = -32768;
        for (int k = 0; k < 2; k++) begin
            doReset();
            sendSamples(160, vals[k], 1'b0);
            idle(6);
            checkFrames(k == 0 ? "fs_pos" : "fs_neg", 5, vals[k]);
        end
    endtask

    task automatic test_gaps();
        doReset();
        sendSamples(192, -500, 1'b1);
        idle(6);
        checkFrames("gaps", 6, -500);
        for (int j = 1; j < pulseCyc.size(); j++) begin
            testsRun++;
            if (pulseCyc[j] - pulseCyc[j-1] !== 64) begin
                testsFailed++;
                $display("[TB] FAIL gaps_spacing[%0d]: got %0d cycles, expected 64", j, pulseCyc[j] - pulseCyc[j-1]);
            end
        end
    endtask

    task automatic test_phase_clr();
        // Pulse on an idle cycle at phase 10: the frame restarts from the next sample.
        doReset();
        sendSamples(10, 200, 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        tbPhase = 0;
        sendSamples(32, 200, 1'b0);
        idle(6);
        checkFrames("clr_idle", 1, 0);

        // Clear coinciding with what would be the phase-31 sample: that strobe is cancelled.
        clearLogs();
        sendSamples(31, 200, 1'b0);
        applyStimulus(1'b1, 200, 1'b1);
        tbPhase = 1;
        sendSamples(31, 200, 1'b0);
        idle(6);
        checkFrames("clr_cancel", 1, 0);

        // Clear just after a phase-31 capture: the in-flight output still completes.
        clearLogs();
        sendSamples(32, 200, 1'b0);
        applyStimulus(1'b0, 0, 1'b1);
        tbPhase = 0;
        idle(6);
        checkFrames("clr_inflight", 1, 0);
    endtask

    task automatic test_reset_midframe();
        doReset();
        sendSamples(49, 1000, 1'b0);
        ARSTN = 1'b0;
        #1;
        testsRun++;
        if (dout !== 16'sd0 || dout_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_outputs: got dout=%0d valid=%b, expected 0 and 0", dout, dout_valid);
        end
        clearLogs();
        repeat (3) applyStimulus(1'b1, 1000, 1'b0);
        testsRun++;
        if (pulseCyc.size() !== 0) begin
            testsFailed++;
            $display("[TB] FAIL midreset_quiet: got %0d pulses during reset, expected 0", pulseCyc.size());
        end
        ARSTN   = 1'b1;
        tbPhase = 0;
        clearLogs();
        sendSamples(32, 1000, 1'b0);
        idle(6);
        checkFrames("midreset_first", 1, 0);
    endtask

    task automatic test_unity();
        doReset();
        sendSamples(128, 1, 1'b0);
        idle(6);
        checkFrames("unity", 4, 1);
    endtask

    task automatic test_ramp();
        longint i1 = 0, i2 = 0, i3 = 0;
        longint snaps[$];
        longint prevS = 0, prevC1 = 0, prevC2 = 0;
        longint c1, c2, c3, q;
        int x;
        doReset();
        for (int n = 0; n < 320; n++) begin
            x = n * 10 - 1600;
            sendSamples(1, x, 1'b0);
            i3 = i3 + i2;
            i2 = i2 + i1;
            i1 = i1 + longint'(x);
            if (n % 32 == 31) snaps.push_back(i3);
        end
        idle(6);
        testsRun++;
        if (pulseCyc.size() !== 10) begin
            testsFailed++;
            $display("[TB] FAIL ramp_count: got %0d pulses, expected 10", pulseCyc.size());
        end
        for (int j = 0; j < snaps.size(); j++) begin
            c1 = snaps[j] - prevS;
            c2 = c1 - prevC1;
            c3 = c2 - prevC2;
            prevS  = snaps[j];
            prevC1 = c1;
            prevC2 = c2;
`ifdef DECIMATE32_ROUND_EN
            q = (c3 + 64'sd16384) >>> 15;
            if (q > 32767) q = 32767;
            if (q < -32768) q = -32768;
`else
            q = c3 >>> 15;
`endif
            if (j >= 2 && j < pulseVal.size()) begin
                testsRun++;
                if (longint'(pulseVal[j]) !== q) begin
                    testsFailed++;
                    $display("[TB] FAIL ramp_value[%0d]: got %0d, expected %0d", j, pulseVal[j], q);
                end
            end
        end
    endtask

    initial begin
        ARSTN     = 1'b0;
        din       = '0;
        din_valid = 1'b0;
        phase_clr = 1'b0;
        test_reset();
        test_dc();
        test_full_scale();
        test_gaps();
        test_phase_clr();
        test_reset_midframe();
        test_unity();
        test_ramp();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
